// File: rtl/irq_prio_ctrl.sv
// -----------------------------------------------------------------------------
// irq_prio_ctrl
//   Edge-triggered interrupt collector with group priority arbitration and a
//   single outstanding grant handshake.
//
//   Each request bit is edge detected into a pending bit. A pending bit is
//   eligible while its channel enable is set. Masked bits stay pending.
//   The lowest-index group with an eligible bit wins. Inside that group the
//   channel is either the lowest index (RR_MODE=0) or the first eligible
//   channel above the group's last acknowledged channel, wrapping (RR_MODE=1).
//   A grant is held stable until acknowledged.
//
// Ports
//   clk        : single clock, rising edge
//   rst_n      : synchronous active-low reset
//   irq_req    : NGRP*NCH request lines, bit g*NCH+c = group g, channel c
//   chan_en    : per-channel enable, shared by all groups
//   irq_ack    : acknowledge of the outstanding grant (ignored when idle)
//   irq_valid  : grant outstanding
//   irq_grp    : granted group index
//   irq_chan   : granted channel index
//   irq_any    : registered OR of all eligible pending bits
//   irq_ovf    : sticky flag, a new edge hit an already pending bit
// -----------------------------------------------------------------------------
module irq_prio_ctrl #(
    parameter int NCH     = 9,
    parameter int NGRP    = 3,
    parameter int RR_MODE = 0
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic [NGRP*NCH-1:0]                         irq_req,
    input  logic [NCH-1:0]                              chan_en,
    input  logic                                        irq_ack,
    output logic                                        irq_valid,
    output logic [((NGRP > 1) ? $clog2(NGRP) : 1)-1:0]  irq_grp,
    output logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0]    irq_chan,
    output logic                                        irq_any,
    output logic                                        irq_ovf
);

    localparam int NBIT = NGRP * NCH;
    localparam int GW   = (NGRP > 1) ? $clog2(NGRP) : 1;
    localparam int CW   = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic {S_IDLE, S_GRANT} state_t;

    state_t          r_state;
    state_t          w_state_next;

    logic [NBIT-1:0] r_prev;
    logic [NBIT-1:0] r_pend;
    logic [CW-1:0]   r_rr_ptr [NGRP];
    logic            r_valid;
    logic [GW-1:0]   r_grp;
    logic [CW-1:0]   r_chan;
    logic            r_any;
    logic            r_ovf;

    logic [NBIT-1:0]    w_rise;
    logic [NBIT-1:0]    w_elig;
    logic [NBIT-1:0]    w_clr;
    logic [NGRP-1:0]    w_grp_hit;
    logic [NGRP*CW-1:0] w_grp_chan;
    logic               w_win_hit;
    logic [GW-1:0]      w_win_grp;
    logic [CW-1:0]      w_win_chan;
    logic               w_ack_grant;
    logic               w_valid_next;
    logic [GW-1:0]      w_grp_next;
    logic [CW-1:0]      w_chan_next;

    // Channel pick inside one group. Scanning downward leaves 'lo' at the
    // lowest eligible channel and 'hi' at the lowest eligible channel above
    // the pointer; the round-robin search wraps to 'lo' when nothing is above.
    function automatic logic [CW-1:0] f_pick(input logic [NCH-1:0] v,
                                             input logic [CW-1:0]  ptr,
                                             input logic           rr);
        logic [CW-1:0] lo;
        logic [CW-1:0] hi;
        logic          hi_hit;
        lo     = '0;
        hi     = '0;
        hi_hit = 1'b0;
        for (int c = NCH - 1; c >= 0; c--) begin
            if (v[c]) begin
                lo = CW'(c);
                if (CW'(c) > ptr) begin
                    hi     = CW'(c);
                    hi_hit = 1'b1;
                end
            end
        end
        f_pick = (rr && hi_hit) ? hi : lo;
    endfunction

    assign w_rise = irq_req & ~r_prev;
    assign w_elig = r_pend & {NGRP{chan_en}};

    for (genvar gi = 0; gi < NGRP; gi++) begin : g_grp
        assign w_grp_hit[gi]            = |w_elig[gi*NCH +: NCH];
        assign w_grp_chan[gi*CW +: CW]  = f_pick(w_elig[gi*NCH +: NCH], r_rr_ptr[gi], RR_MODE != 0);
    end

    // Lowest-index group with any eligible bit wins.
    always_comb begin
        w_win_hit  = 1'b0;
        w_win_grp  = '0;
        w_win_chan = '0;
        for (int g = NGRP - 1; g >= 0; g--) begin
            if (w_grp_hit[g]) begin
                w_win_hit  = 1'b1;
                w_win_grp  = GW'(g);
                w_win_chan = w_grp_chan[g*CW +: CW];
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_valid_next = r_valid;
        w_grp_next   = r_grp;
        w_chan_next  = r_chan;
        w_ack_grant  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_win_hit) begin
                    w_state_next = S_GRANT;
                    w_valid_next = 1'b1;
                    w_grp_next   = w_win_grp;
                    w_chan_next  = w_win_chan;
                end
            end
            S_GRANT: begin
                if (irq_ack) begin
                    w_ack_grant  = 1'b1;
                    w_valid_next = 1'b0;
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // One-hot clear of the granted bit on acknowledge.
    assign w_clr = w_ack_grant ? (NBIT'(1) << (int'(r_grp) * NCH + int'(r_chan))) : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_prev  <= '0;
            r_pend  <= '0;
            r_valid <= 1'b0;
            r_grp   <= '0;
            r_chan  <= '0;
            r_any   <= 1'b0;
            r_ovf   <= 1'b0;
            for (int g = 0; g < NGRP; g++) begin
                r_rr_ptr[g] <= '0;
            end
        end else begin
            r_state <= w_state_next;
            r_valid <= w_valid_next;
            r_grp   <= w_grp_next;
            r_chan  <= w_chan_next;
            r_prev  <= irq_req;
            // Set after clear: a new edge on the bit being acknowledged survives.
            r_pend  <= (r_pend & ~w_clr) | w_rise;
            r_any   <= |w_elig;
            if (|(w_rise & r_pend & ~w_clr)) begin
                r_ovf <= 1'b1;
            end
            if (w_ack_grant) begin
                r_rr_ptr[r_grp] <= r_chan;
            end
        end
    end

    assign irq_valid = r_valid;
    assign irq_grp   = r_grp;
    assign irq_chan  = r_chan;
    assign irq_any   = r_any;
    assign irq_ovf   = r_ovf;

endmodule

// File: tb/tb_irq_prio_ctrl.sv
// -----------------------------------------------------------------------------
// tb_irq_prio_ctrl
//   Two instances: u_fix (fixed priority) and u_rr (round-robin), each with its
//   own inputs and a shared reset. A behavioural model of each instance is
//   stepped once per clock from the inputs captured at that rising edge, and
//   every falling edge compares all outputs of both instances to it. Directed
//   scenarios add literal expectations on top.
// -----------------------------------------------------------------------------
module tb_irq_prio_ctrl;

    localparam int NCH  = 9;
    localparam int NGRP = 3;
    localparam int NB   = NCH * NGRP;

    logic          clk;
    logic          rst_n;
    logic [NB-1:0] req_a, req_b;
    logic [NCH-1:0] en_a, en_b;
    logic          ack_a, ack_b;

    logic          f_valid, f_any, f_ovf;
    logic [1:0]    f_grp;
    logic [3:0]    f_chan;
    logic          rr_valid, rr_any, rr_ovf;
    logic [1:0]    rr_grp;
    logic [3:0]    rr_chan;

    int n_tests = 0;
    int n_fail  = 0;

    irq_prio_ctrl #(.NCH(NCH), .NGRP(NGRP), .RR_MODE(0)) u_fix (
        .clk(clk), .rst_n(rst_n), .irq_req(req_a), .chan_en(en_a), .irq_ack(ack_a),
        .irq_valid(f_valid), .irq_grp(f_grp), .irq_chan(f_chan),
        .irq_any(f_any), .irq_ovf(f_ovf)
    );

    irq_prio_ctrl #(.NCH(NCH), .NGRP(NGRP), .RR_MODE(1)) u_rr (
        .clk(clk), .rst_n(rst_n), .irq_req(req_b), .chan_en(en_b), .irq_ack(ack_b),
        .irq_valid(rr_valid), .irq_grp(rr_grp), .irq_chan(rr_chan),
        .irq_any(rr_any), .irq_ovf(rr_ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit [NB-1:0] m_pend [2];
    bit [NB-1:0] m_prev [2];
    bit          m_gnt  [2];
    int          m_grp  [2];
    int          m_chan [2];
    bit          m_any  [2];
    bit          m_ovf  [2];
    int          m_ptr  [2][NGRP];

    // inputs as seen at the latest rising edge
    logic          s_rst_n;
    logic [NB-1:0] s_req  [2];
    logic [NCH-1:0] s_en  [2];
    logic          s_ack  [2];

    always @(posedge clk) begin
        s_rst_n  <= rst_n;
        s_req[0] <= req_a;  s_en[0] <= en_a;  s_ack[0] <= ack_a;
        s_req[1] <= req_b;  s_en[1] <= en_b;  s_ack[1] <= ack_b;
    end

    // k=1 is the round-robin instance
    task automatic model_step(input int k);
        bit [NB-1:0] elig;
        int clr, wg, wc, best, d;
        bit rise;
        if (!s_rst_n) begin
            m_pend[k] = '0; m_prev[k] = '0; m_gnt[k] = 0; m_grp[k] = 0;
            m_chan[k] = 0;  m_any[k]  = 0;  m_ovf[k] = 0;
            for (int g = 0; g < NGRP; g++) m_ptr[k][g] = 0;
            return;
        end
        for (int i = 0; i < NB; i++) elig[i] = m_pend[k][i] & s_en[k][i % NCH];
        clr = -1;
        if (m_gnt[k] && s_ack[k]) clr = m_grp[k] * NCH + m_chan[k];
        wg = -1; wc = -1;
        for (int g = 0; g < NGRP; g++) begin
            if (wg < 0) begin
                wc = -1; best = NCH;
                for (int c = 0; c < NCH; c++) begin
                    if (elig[g*NCH + c]) begin
                        // distance of c along the search order starting after the pointer
                        d = (k == 1) ? (c - m_ptr[k][g] - 1 + 2 * NCH) % NCH : c;
                        if (d < best) begin best = d; wc = c; end
                    end
                end
                if (wc >= 0) wg = g;
            end
        end
        for (int i = 0; i < NB; i++) begin
            rise = s_req[k][i] && !m_prev[k][i];
            if (rise && m_pend[k][i] && i != clr) m_ovf[k] = 1;
            if (i == clr) m_pend[k][i] = 0;
            if (rise) m_pend[k][i] = 1;
        end
        m_prev[k] = s_req[k];
        m_any[k]  = |elig;
        if (clr >= 0) begin
            $display("[TB] %s ack grp=%0d chan=%0d", (k == 1) ? "rr" : "fix", m_grp[k], m_chan[k]);
            m_ptr[k][m_grp[k]] = m_chan[k];
            m_gnt[k] = 0;
        end else if (!m_gnt[k] && wg >= 0) begin
            m_gnt[k] = 1; m_grp[k] = wg; m_chan[k] = wc;
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            model_step(0);
            model_step(1);
            check("fix_valid", 32'(f_valid), 32'(m_gnt[0]));
            check("fix_grp",   32'(f_grp),   32'(m_grp[0]));
            check("fix_chan",  32'(f_chan),  32'(m_chan[0]));
            check("fix_any",   32'(f_any),   32'(m_any[0]));
            check("fix_ovf",   32'(f_ovf),   32'(m_ovf[0]));
            check("rr_valid",  32'(rr_valid), 32'(m_gnt[1]));
            check("rr_grp",    32'(rr_grp),   32'(m_grp[1]));
            check("rr_chan",   32'(rr_chan),  32'(m_chan[1]));
            check("rr_any",    32'(rr_any),   32'(m_any[1]));
            check("rr_ovf",    32'(rr_ovf),   32'(m_ovf[1]));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        rst_n = 1'b0;
        req_a = '0; en_a = '1; ack_a = 1'b0;
        req_b = '0; en_b = '1; ack_b = 1'b0;
        tick(3);
        check("rst_valid", 32'(f_valid), 0);
        check("rst_any",   32'(f_any),   0);
        check("rst_ovf",   32'(f_ovf),   0);
        rst_n = 1'b1;
        tick(1);

        // ack while idle does nothing
        ack_a = 1'b1; tick(1); ack_a = 1'b0;
        check("idle_ack_valid", 32'(f_valid), 0);

        // single event on bit 13 -> group 1 channel 4
        req_a[13] = 1'b1; tick(1); req_a[13] = 1'b0; tick(1);
        check("s1_valid", 32'(f_valid), 1);
        check("s1_grp",   32'(f_grp),   1);
        check("s1_chan",  32'(f_chan),  4);
        ack_a = 1'b1; tick(1); ack_a = 1'b0;
        check("s1_ack_valid", 32'(f_valid), 0);
        tick(1);
        check("s1_any_clear", 32'(f_any),   0);
        check("s1_no_regrant", 32'(f_valid), 0);

        // group priority: bits 2 and 20 together
        req_a[2] = 1'b1; req_a[20] = 1'b1; tick(2);
        check("gp_valid0", 32'(f_valid), 1);
        check("gp_grp0",   32'(f_grp),   0);
        check("gp_chan0",  32'(f_chan),  2);
        ack_a = 1'b1; tick(1); ack_a = 1'b0;
        check("gp_gap", 32'(f_valid), 0);
        tick(1);
        check("gp_valid2", 32'(f_valid), 1);
        check("gp_grp2",   32'(f_grp),   2);
        check("gp_chan2",  32'(f_chan),  2);
        ack_a = 1'b1; req_a[2] = 1'b0; req_a[20] = 1'b0; tick(1); ack_a = 1'b0; tick(1);

        // masking: channel 5 disabled, then enabled
        en_a[5] = 1'b0; req_a[5] = 1'b1; tick(3);
        check("mask_valid", 32'(f_valid), 0);
        check("mask_any",   32'(f_any),   0);
        en_a[5] = 1'b1; tick(1);
        check("unmask_any",   32'(f_any),   1);
        check("unmask_valid", 32'(f_valid), 1);
        check("unmask_grp",   32'(f_grp),   0);
        check("unmask_chan",  32'(f_chan),  5);
        ack_a = 1'b1; req_a[5] = 1'b0; tick(1); ack_a = 1'b0; tick(1);

        // coincidence of re-rise and ack on bit 7, then overflow
        req_a[7] = 1'b1; tick(1); req_a[7] = 1'b0; tick(1);
        check("co_valid", 32'(f_valid), 1);
        check("co_chan",  32'(f_chan),  7);
        req_a[7] = 1'b1; ack_a = 1'b1; tick(1); req_a[7] = 1'b0; ack_a = 1'b0;
        check("co_ack_valid", 32'(f_valid), 0);
        check("co_no_ovf",    32'(f_ovf),   0);
        tick(1);
        check("co_regrant_valid", 32'(f_valid), 1);
        check("co_regrant_chan",  32'(f_chan),  7);
        req_a[7] = 1'b1; tick(1);
        check("ovf_set",        32'(f_ovf),   1);
        check("ovf_hold_valid", 32'(f_valid), 1);
        check("ovf_hold_chan",  32'(f_chan),  7);
        req_a[7] = 1'b0; ack_a = 1'b1; tick(1); ack_a = 1'b0; tick(2);
        check("ovf_sticky", 32'(f_ovf),   1);
        check("ovf_idle",   32'(f_valid), 0);

        // round-robin: prime pointer of group 0 to channel 8
        req_b[8] = 1'b1; tick(1); req_b[8] = 1'b0; tick(1);
        check("rr_prime_chan", 32'(rr_chan), 8);
        ack_b = 1'b1; tick(1); ack_b = 1'b0; tick(1);
        req_b[0] = 1'b1; req_b[3] = 1'b1; req_b[8] = 1'b1; tick(1); req_b = '0; tick(1);
        check("rr_1_valid", 32'(rr_valid), 1);
        check("rr_1_chan",  32'(rr_chan),  0);
        ack_b = 1'b1; tick(1); ack_b = 1'b0; tick(1);
        check("rr_2_chan", 32'(rr_chan), 3);
        ack_b = 1'b1; tick(1); ack_b = 1'b0; tick(1);
        check("rr_3_chan", 32'(rr_chan), 8);
        req_b[0] = 1'b1; ack_b = 1'b1; tick(1); req_b[0] = 1'b0; ack_b = 1'b0; tick(1);
        check("rr_wrap_valid", 32'(rr_valid), 1);
        check("rr_wrap_chan",  32'(rr_chan),  0);
        ack_b = 1'b1; tick(1); ack_b = 1'b0; tick(1);
        req_b[0] = 1'b1; req_b[5] = 1'b1; tick(1); req_b = '0; tick(1);
        check("rr_skip_chan", 32'(rr_chan), 5);
        ack_b = 1'b1; tick(1); ack_b = 1'b0; tick(1);
        check("rr_next_chan", 32'(rr_chan), 0);
        ack_b = 1'b1; tick(1); ack_b = 1'b0; tick(1);

        // reset in the middle of a grant, request held through release
        req_a[22] = 1'b1; req_b[1] = 1'b1; tick(2);
        check("rm_valid_before", 32'(f_valid), 1);
        rst_n = 1'b0; tick(1);
        check("rm_valid", 32'(f_valid),  0);
        check("rm_grp",   32'(f_grp),    0);
        check("rm_chan",  32'(f_chan),   0);
        check("rm_any",   32'(f_any),    0);
        check("rm_ovf",   32'(f_ovf),    0);
        check("rm_rr_valid", 32'(rr_valid), 0);
        tick(1); rst_n = 1'b1; tick(1);
        check("rel_pend_only", 32'(f_valid), 0);
        tick(1);
        check("rel_valid", 32'(f_valid), 1);
        check("rel_grp",   32'(f_grp),   2);
        check("rel_chan",  32'(f_chan),  4);
        ack_a = 1'b1; ack_b = 1'b1; tick(1); ack_a = 1'b0; ack_b = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("rel_single_event", 32'(f_valid), 0);
            tick(1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/irq_prio_ctrl.md
IRQ_PRIO_CTRL -- requirements
Module: irq_prio_ctrl

Interface
REQ-001 The block SHALL have parameter NCH, default 9, channels per group.
REQ-002 The block SHALL have parameter NGRP, default 3, priority groups; group 0 is highest priority.
REQ-003 The block SHALL have parameter RR_MODE, default 0; 0 selects fixed priority within a group, 1 selects round-robin within a group.
REQ-004 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1, reset; it is synchronous and active-low.
REQ-006 The block SHALL have port irq_req, input, NGRP*NCH, request lines; bit g*NCH+c is group g, channel c.
REQ-007 The block SHALL have port chan_en, input, NCH, per-channel enable mask applied to every group.
REQ-008 The block SHALL have port irq_ack, input, 1, acknowledge of the current grant.
REQ-009 The block SHALL have port irq_valid, output, 1, grant outstanding.
REQ-010 The block SHALL have port irq_grp, output, clog2(NGRP) (min 1), index of the granted group.
REQ-011 The block SHALL have port irq_chan, output, clog2(NCH) (min 1), index of the granted channel.
REQ-012 The block SHALL have port irq_any, output, 1, registered OR of all eligible pending bits.
REQ-013 The block SHALL have port irq_ovf, output, 1, sticky lost-event flag.

Function
REQ-014 A per-bit previous-value register of irq_req SHALL provide edge detection; a rising edge SHALL set pend[i] at that clock edge.
REQ-015 A rising edge on a bit whose pend is already 1, and which is not cleared in that cycle, SHALL set irq_ovf; irq_ovf SHALL clear only on reset.
REQ-016 Bit i SHALL be eligible when pend[i]=1 and chan_en[i mod NCH]=1; masked pending bits SHALL be retained, not dropped.
REQ-017 Arbitration SHALL select the lowest-index group containing an eligible bit.
REQ-018 Within that group, RR_MODE=0 SHALL select the lowest eligible channel index.
REQ-019 Within that group, RR_MODE=1 SHALL search upward from (rr_ptr[g]+1) mod NCH, wrapping from NCH-1 to 0.
REQ-020 There SHALL be one rr_ptr per group; it SHALL update only on acknowledge of a grant in that group, to the granted channel.
REQ-021 The FSM SHALL have exactly two states, IDLE and GRANT.
REQ-022 In IDLE, if any bit is eligible, the FSM SHALL register the winner into irq_grp/irq_chan, set irq_valid=1, and enter GRANT at the same edge.
REQ-023 In GRANT, irq_valid, irq_grp and irq_chan SHALL hold stable regardless of new requests or chan_en changes until irq_ack=1 is sampled.
REQ-024 On irq_ack=1 in GRANT, the FSM SHALL clear pend of the granted bit, clear irq_valid, and return to IDLE.
REQ-025 irq_valid SHALL therefore be low for at least one cycle between consecutive grants.
REQ-026 irq_ack sampled in IDLE SHALL be ignored.
REQ-027 If a rising edge on the granted bit coincides with its ack, set SHALL win: pend stays 1 and irq_ovf is not set.
REQ-028 Latency: req rises before edge E0, pend is set at E0, and irq_valid=1 after E1 if the FSM was IDLE and the bit won arbitration.
REQ-029 irq_any SHALL be updated every edge from the eligible set present before that edge.

Reset
REQ-030 With rst_n=0 at a rising edge, the block SHALL clear pend, the previous-value register, rr_ptr, irq_valid, irq_grp, irq_chan, irq_any and irq_ovf, and return to IDLE.
REQ-031 Reset SHALL override ack and requests in the same cycle; a grant in progress SHALL be abandoned without handshake.
REQ-032 An irq_req bit held high through reset release SHALL register exactly one event at the first edge with rst_n=1.

Verification
REQ-033 The bench SHALL cover single event: NCH=9, NGRP=3, chan_en=all 1s, pulse bit 13 -> after E1, irq_valid=1, irq_grp=1, irq_chan=4; ack -> valid=0, pend[13]=0.
REQ-034 The bench SHALL cover group priority: bits 2 and 20 rise together -> grant grp0/ch2; after ack and one idle cycle, grant grp2/ch2.
REQ-035 The bench SHALL cover round-robin: RR_MODE=1, bits 0, 3 and 8 pending -> grant order ch0, ch3, ch8; re-raise bit 0 -> ch0 after ch8 (wrap).
REQ-036 The bench SHALL cover masking: chan_en[5]=0, bit 5 rises -> no grant, irq_any=0; set chan_en[5]=1 -> irq_any=1 next edge, grant ch5.
REQ-037 The bench SHALL cover overflow and coincidence: two rising edges on bit 7 with no ack -> irq_ovf=1; re-rise bit 7 in the same cycle as its ack -> pend[7] stays 1.
REQ-038 The bench SHALL cover reset mid-grant: rst_n=0 while irq_valid=1 -> all outputs 0 next edge; irq_req bit held high through release -> exactly one grant.
